// File: rtl/mips_pkg.sv
// Shared pipeline definitions: load/store access-type encodings and
// the helpers the memory stage uses to decode them.
package mips_pkg;

    typedef enum logic [2:0] {
        BHW_BYTE  = 3'b000,
        BHW_HALF  = 3'b001,
        BHW_WORD  = 3'b011,
        BHW_BYTEU = 3'b100,
        BHW_HALFU = 3'b101
    } bhw_e;

    typedef enum logic [1:0] {
        SIZE_BYTE,
        SIZE_HALF,
        SIZE_WORD
    } accessSize_e;

    // Any code outside the five defined encodings behaves as a word access.
    function automatic accessSize_e decodeSize(input logic [2:0] bhw);
        case (bhw)
            BHW_BYTE, BHW_BYTEU: return SIZE_BYTE;
            BHW_HALF, BHW_HALFU: return SIZE_HALF;
            default:             return SIZE_WORD;
        endcase
    endfunction

    function automatic logic isZeroExtend(input logic [2:0] bhw);
        return (bhw == BHW_BYTEU) || (bhw == BHW_HALFU);
    endfunction

endpackage

// File: rtl/data_memory.sv
// Word-organised RAM with per-byte write enables, an asynchronous pipeline
// read port and an independent asynchronous debug read port.
module data_memory #(
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [3:0]        i_byte_en,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wr_data,
    output logic [31:0]       o_rd_data,
    input  logic [ADDR_W-1:0] i_du_addr,
    output logic [31:0]       o_du_data
);

    logic [31:0] memArray [0:(1<<ADDR_W)-1];

    // Contents are deliberately not reset so they survive a pipeline reset.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int lane = 0; lane < 4; lane++) begin
                if (i_byte_en[lane]) begin
                    memArray[i_addr][lane*8 +: 8] <= i_wr_data[lane*8 +: 8];
                end
            end
        end
    end

    assign o_rd_data = memArray[i_addr];
    assign o_du_data = memArray[i_du_addr];

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: alignment checking, byte-lane steering for stores,
// lane selection and extension for loads, and the M/WB pipeline registers.
module mem_stage #(
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_halt,
    input  logic [31:0]       i_m_alu_result,
    input  logic [31:0]       i_m_write_data,
    input  logic [4:0]        i_m_rd,
    input  logic              i_m_mem_read,
    input  logic              i_m_mem_write,
    input  logic              i_m_mem_to_reg,
    input  logic              i_m_reg_write,
    input  logic [2:0]        i_m_bhw_type,
    input  logic [ADDR_W-1:0] i_du_addr,
    output logic [31:0]       o_wb_read_data,
    output logic [31:0]       o_wb_alu_result,
    output logic [4:0]        o_wb_rd,
    output logic              o_wb_mem_to_reg,
    output logic              o_wb_reg_write,
    output logic              o_wb_misaligned,
    output logic [31:0]       o_du_data
);
    import mips_pkg::*;

    accessSize_e       accessSize;
    logic              zeroExtend;
    logic [1:0]        byteOff;
    logic [ADDR_W-1:0] wordAddr;
    logic              misaligned;
    logic              misalignedAccess;
    logic              memWe;
    logic [3:0]        byteEn;
    logic [31:0]       wrData;
    logic [31:0]       rdWord;
    logic [7:0]        laneByte;
    logic [15:0]       laneHalf;
    logic [31:0]       loadData;

    logic [31:0] readData_d, readData_q;
    logic [31:0] aluResult_q;
    logic [4:0]  rd_q;
    logic        memToReg_q;
    logic        regWrite_d, regWrite_q;
    logic        misaligned_d, misaligned_q;

    assign accessSize = decodeSize(i_m_bhw_type);
    assign zeroExtend = isZeroExtend(i_m_bhw_type);
    assign byteOff    = i_m_alu_result[1:0];
    assign wordAddr   = i_m_alu_result[ADDR_W+1:2];

    always_comb begin
        misaligned = 1'b0;
        case (accessSize)
            SIZE_HALF: misaligned = byteOff[0];
            SIZE_WORD: misaligned = (byteOff != 2'b00);
            default:   misaligned = 1'b0;
        endcase
    end

    assign misalignedAccess = misaligned && (i_m_mem_read || i_m_mem_write);

    // Gating on reset keeps a store that coincides with reset out of memory.
    assign memWe = i_m_mem_write && !misaligned && !i_halt && !i_reset;

    // Narrow store data is replicated across lanes; byteEn picks the live one.
    always_comb begin
        byteEn = 4'b0000;
        wrData = i_m_write_data;
        case (accessSize)
            SIZE_BYTE: begin
                byteEn = 4'b0001 << byteOff;
                wrData = {4{i_m_write_data[7:0]}};
            end
            SIZE_HALF: begin
                byteEn = byteOff[1] ? 4'b1100 : 4'b0011;
                wrData = {2{i_m_write_data[15:0]}};
            end
            default: begin
                byteEn = 4'b1111;
                wrData = i_m_write_data;
            end
        endcase
    end

    data_memory #(
        .ADDR_W(ADDR_W)
    ) u_data_memory (
        .i_clk     (i_clk),
        .i_we      (memWe),
        .i_byte_en (byteEn),
        .i_addr    (wordAddr),
        .i_wr_data (wrData),
        .o_rd_data (rdWord),
        .i_du_addr (i_du_addr),
        .o_du_data (o_du_data)
    );

    always_comb begin
        laneByte = rdWord[{byteOff, 3'b000} +: 8];
        laneHalf = byteOff[1] ? rdWord[31:16] : rdWord[15:0];
        loadData = rdWord;
        case (accessSize)
            SIZE_BYTE: loadData = zeroExtend ? {24'h0, laneByte} : {{24{laneByte[7]}}, laneByte};
            SIZE_HALF: loadData = zeroExtend ? {16'h0, laneHalf} : {{16{laneHalf[15]}}, laneHalf};
            default:   loadData = rdWord;
        endcase
    end

    assign readData_d   = (i_m_mem_read && !misaligned) ? loadData : 32'h0;
    assign regWrite_d   = i_m_reg_write && !misalignedAccess;
    assign misaligned_d = misalignedAccess;

    // Halt freezes the whole M/WB register set.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            readData_q   <= 32'h0;
            aluResult_q  <= 32'h0;
            rd_q         <= 5'h0;
            memToReg_q   <= 1'b0;
            regWrite_q   <= 1'b0;
            misaligned_q <= 1'b0;
        end else if (!i_halt) begin
            readData_q   <= readData_d;
            aluResult_q  <= i_m_alu_result;
            rd_q         <= i_m_rd;
            memToReg_q   <= i_m_mem_to_reg;
            regWrite_q   <= regWrite_d;
            misaligned_q <= misaligned_d;
        end
    end

    assign o_wb_read_data  = readData_q;
    assign o_wb_alu_result = aluResult_q;
    assign o_wb_rd         = rd_q;
    assign o_wb_mem_to_reg = memToReg_q;
    assign o_wb_reg_write  = regWrite_q;
    assign o_wb_misaligned = misaligned_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed testbench for mem_stage: a table of single-cycle load/store
// vectors followed by hand-written halt and reset sequences.
module tb_mem_stage;

    localparam int ADDR_W = 8;

    logic              clk;
    logic              reset;
    logic              halt;
    logic [31:0]       aluResult;
    logic [31:0]       writeData;
    logic [4:0]        rd;
    logic              memRead;
    logic              memWrite;
    logic              memToReg;
    logic              regWrite;
    logic [2:0]        bhwType;
    logic [ADDR_W-1:0] duAddr;
    logic [31:0]       wbReadData;
    logic [31:0]       wbAluResult;
    logic [4:0]        wbRd;
    logic              wbMemToReg;
    logic              wbRegWrite;
    logic              wbMisaligned;
    logic [31:0]       duData;

    int testsRun = 0;
    int testsFailed = 0;

    mem_stage #(
        .ADDR_W(ADDR_W)
    ) dut (
        .i_clk           (clk),
        .i_reset         (reset),
        .i_halt          (halt),
        .i_m_alu_result  (aluResult),
        .i_m_write_data  (writeData),
        .i_m_rd          (rd),
        .i_m_mem_read    (memRead),
        .i_m_mem_write   (memWrite),
        .i_m_mem_to_reg  (memToReg),
        .i_m_reg_write   (regWrite),
        .i_m_bhw_type    (bhwType),
        .i_du_addr       (duAddr),
        .o_wb_read_data  (wbReadData),
        .o_wb_alu_result (wbAluResult),
        .o_wb_rd         (wbRd),
        .o_wb_mem_to_reg (wbMemToReg),
        .o_wb_reg_write  (wbRegWrite),
        .o_wb_misaligned (wbMisaligned),
        .o_du_data       (duData)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       name;
        logic [31:0] alu;
        logic [31:0] wdata;
        logic        rdEn;
        logic        wrEn;
        logic        rw;
        logic [2:0]  bhw;
        logic [7:0]  du;
        logic [31:0] expRead;
        logic        expMis;
        logic        expRw;
        logic [31:0] expDu;
    } vec_t;

    vec_t vecs[$];

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b011;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] UND = 3'b010;

    function automatic vec_t mk(string name, logic [31:0] alu, logic [31:0] wdata,
                                logic rdEn, logic wrEn, logic rw, logic [2:0] bhw,
                                logic [7:0] du, logic [31:0] expRead, logic expMis,
                                logic expRw, logic [31:0] expDu);
        vec_t v;
        v.name = name; v.alu = alu; v.wdata = wdata; v.rdEn = rdEn; v.wrEn = wrEn;
        v.rw = rw; v.bhw = bhw; v.du = du; v.expRead = expRead; v.expMis = expMis;
        v.expRw = expRw; v.expDu = expDu;
        return v;
    endfunction

    task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic driveIdle();
        aluResult = 32'h0; writeData = 32'h0; rd = 5'h0;
        memRead = 1'b0; memWrite = 1'b0; memToReg = 1'b0; regWrite = 1'b0;
        bhwType = LW; halt = 1'b0;
    endtask

    task automatic drive(logic [31:0] alu, logic [31:0] wdata, logic [4:0] rdId,
                         logic rdEn, logic wrEn, logic rw, logic [2:0] bhw);
        aluResult = alu; writeData = wdata; rd = rdId;
        memRead = rdEn; memWrite = wrEn; memToReg = rdEn; regWrite = rw;
        bhwType = bhw;
    endtask

    task automatic applyStimulus(vec_t v, int idx);
        @(negedge clk);
        drive(v.alu, v.wdata, idx[4:0], v.rdEn, v.wrEn, v.rw, v.bhw);
        duAddr = v.du;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(vec_t v, int idx);
        check32({v.name, ".read"},     wbReadData,           v.expRead);
        check32({v.name, ".mis"},      {31'h0, wbMisaligned}, {31'h0, v.expMis});
        check32({v.name, ".regwrite"}, {31'h0, wbRegWrite},   {31'h0, v.expRw});
        check32({v.name, ".alu"},      wbAluResult,          v.alu);
        check32({v.name, ".rd"},       {27'h0, wbRd},         {27'h0, idx[4:0]});
        check32({v.name, ".m2r"},      {31'h0, wbMemToReg},   {31'h0, v.rdEn});
        check32({v.name, ".du"},       duData,               v.expDu);
    endtask

    task automatic checkWbZero(string name);
        check32({name, ".read"}, wbReadData, 32'h0);
        check32({name, ".alu"},  wbAluResult, 32'h0);
        check32({name, ".ctl"},  {24'h0, wbRd, wbMemToReg, wbRegWrite, wbMisaligned}, 32'h0);
    endtask

    initial begin
        // name, alu, wdata, rd, wr, rw, bhw, du, expRead, expMis, expRw, expDu
        vecs.push_back(mk("sw10",    32'h10,   32'h800000F0, 0, 1, 0, LW,  8'd4, 32'h0,        0, 0, 32'h800000F0));
        vecs.push_back(mk("lb10",    32'h10,   32'h0,        1, 0, 1, LB,  8'd4, 32'hFFFFFFF0, 0, 1, 32'h800000F0));
        vecs.push_back(mk("lbu10",   32'h10,   32'h0,        1, 0, 1, LBU, 8'd4, 32'h000000F0, 0, 1, 32'h800000F0));
        vecs.push_back(mk("lb13",    32'h13,   32'h0,        1, 0, 1, LB,  8'd4, 32'hFFFFFF80, 0, 1, 32'h800000F0));
        vecs.push_back(mk("lhu12",   32'h12,   32'h0,        1, 0, 1, LHU, 8'd4, 32'h00008000, 0, 1, 32'h800000F0));
        vecs.push_back(mk("lh12",    32'h12,   32'h0,        1, 0, 1, LH,  8'd4, 32'hFFFF8000, 0, 1, 32'h800000F0));
        vecs.push_back(mk("sw20",    32'h20,   32'h11112222, 0, 1, 0, LW,  8'd8, 32'h0,        0, 0, 32'h11112222));
        vecs.push_back(mk("sh22",    32'h22,   32'hFFFF1234, 0, 1, 0, LH,  8'd8, 32'h0,        0, 0, 32'h12342222));
        vecs.push_back(mk("lw20",    32'h20,   32'h0,        1, 0, 1, LW,  8'd8, 32'h12342222, 0, 1, 32'h12342222));
        vecs.push_back(mk("lhu22",   32'h22,   32'h0,        1, 0, 1, LHU, 8'd8, 32'h00001234, 0, 1, 32'h12342222));
        vecs.push_back(mk("lh20",    32'h20,   32'h0,        1, 0, 1, LH,  8'd8, 32'h00002222, 0, 1, 32'h12342222));
        vecs.push_back(mk("sb21",    32'h21,   32'h000000AB, 0, 1, 0, LB,  8'd8, 32'h0,        0, 0, 32'h1234AB22));
        vecs.push_back(mk("lw20b",   32'h20,   32'h0,        1, 0, 1, LW,  8'd8, 32'h1234AB22, 0, 1, 32'h1234AB22));
        vecs.push_back(mk("lwmis",   32'h13,   32'h0,        1, 0, 1, LW,  8'd4, 32'h0,        1, 0, 32'h800000F0));
        vecs.push_back(mk("swmis",   32'h13,   32'hCAFEBABE, 0, 1, 0, LW,  8'd4, 32'h0,        1, 0, 32'h800000F0));
        vecs.push_back(mk("lhmis",   32'h11,   32'h0,        1, 0, 1, LH,  8'd4, 32'h0,        1, 0, 32'h800000F0));
        vecs.push_back(mk("shmis",   32'h23,   32'h0000BEEF, 0, 1, 0, LHU, 8'd8, 32'h0,        1, 0, 32'h1234AB22));
        vecs.push_back(mk("lbu23",   32'h23,   32'h0,        1, 0, 1, LBU, 8'd8, 32'h00000012, 0, 1, 32'h1234AB22));
        vecs.push_back(mk("rmw20",   32'h20,   32'h00000099, 1, 1, 1, LW,  8'd8, 32'h1234AB22, 0, 1, 32'h00000099));
        vecs.push_back(mk("lw20c",   32'h20,   32'h0,        1, 0, 1, LW,  8'd8, 32'h00000099, 0, 1, 32'h00000099));
        vecs.push_back(mk("und20",   32'h20,   32'h0,        1, 0, 1, UND, 8'd8, 32'h00000099, 0, 1, 32'h00000099));
        vecs.push_back(mk("und22",   32'h22,   32'h0,        1, 0, 1, UND, 8'd8, 32'h0,        1, 0, 32'h00000099));
        vecs.push_back(mk("aluop",   32'h13,   32'h0,        0, 0, 1, LW,  8'd8, 32'h0,        0, 1, 32'h00000099));
        vecs.push_back(mk("swwrap",  32'h410,  32'h55667788, 0, 1, 0, LW,  8'd4, 32'h0,        0, 0, 32'h55667788));
        vecs.push_back(mk("lwwrap",  32'h10,   32'h0,        1, 0, 1, LW,  8'd4, 32'h55667788, 0, 1, 32'h55667788));
        vecs.push_back(mk("lhwrap",  32'h1012, 32'h0,        1, 0, 1, LH,  8'd4, 32'h00005566, 0, 1, 32'h55667788));

        reset = 1'b1;
        duAddr = '0;
        driveIdle();
        #1;
        checkWbZero("reset0");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i], i);
            checkOutput(vecs[i], i);
        end

        // Halt: a store under halt must neither write nor disturb the WB registers.
        @(negedge clk);
        drive(32'h40, 32'h0BADF00D, 5'd0, 0, 1, 0, LW);
        duAddr = 8'd16;
        @(negedge clk);
        drive(32'h40, 32'h0, 5'd7, 1, 0, 1, LW);
        @(posedge clk);
        #1;
        check32("preHalt.read", wbReadData, 32'h0BADF00D);
        @(negedge clk);
        drive(32'h40, 32'hA5A5A5A5, 5'd9, 0, 1, 0, LW);
        halt = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check32("halt.du",   duData,      32'h0BADF00D);
        check32("halt.read", wbReadData,  32'h0BADF00D);
        check32("halt.alu",  wbAluResult, 32'h40);
        check32("halt.ctl",  {27'h0, wbRd, wbMemToReg, wbRegWrite, wbMisaligned}, {27'h0, 5'd7, 1'b1, 1'b1, 1'b0});
        @(negedge clk);
        halt = 1'b0;
        #1;
        check32("preEdge.du", duData, 32'h0BADF00D);
        @(posedge clk);
        #1;
        check32("unhalt.du",   duData,     32'hA5A5A5A5);
        check32("unhalt.read", wbReadData, 32'h0);
        check32("unhalt.ctl",  {27'h0, wbRd, wbMemToReg, wbRegWrite, wbMisaligned}, {27'h0, 5'd9, 1'b0, 1'b0, 1'b0});

        // Mid-cycle reset clears WB at once; memory survives and a coincident store is dropped.
        @(negedge clk);
        drive(32'h0, 32'hDEADBEEF, 5'd0, 0, 1, 0, LW);
        duAddr = 8'd0;
        @(negedge clk);
        drive(32'h0, 32'h0, 5'd3, 1, 0, 1, LW);
        @(posedge clk);
        #1;
        check32("preReset.read", wbReadData, 32'hDEADBEEF);
        #1;
        reset = 1'b1;
        drive(32'h0, 32'h12345678, 5'd4, 0, 1, 1, LW);
        #1;
        checkWbZero("asyncReset");
        check32("asyncReset.du", duData, 32'hDEADBEEF);
        @(posedge clk);
        #1;
        check32("resetStore.du", duData, 32'hDEADBEEF);
        checkWbZero("resetHeld");
        @(negedge clk);
        reset = 1'b0;
        driveIdle();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter ADDR_W, default 8, word-address width; the memory holds 2^ADDR_W 32-bit words.
REQ-002 i_clk  in  1  single clock; all state updates on the rising edge.
REQ-003 i_reset  in  1  reset, asynchronous and active-high.
REQ-004 i_halt  in  1  freeze; when 1, the memory and all output registers hold.
REQ-005 i_m_alu_result  in  32  byte address for loads/stores; also the pass-through ALU result.
REQ-006 i_m_write_data  in  32  store data; the low byte/halfword is used for narrow stores.
REQ-007 i_m_rd  in  5  destination register ID.
REQ-008 i_m_mem_read, i_m_mem_write, i_m_mem_to_reg, i_m_reg_write  in  1 each  control bits from EX/M.
REQ-009 i_m_bhw_type  in  3  access type: 000 byte signed, 001 half signed, 011 word, 100 byte unsigned, 101 half unsigned; other codes are treated as word.
REQ-010 i_du_addr  in  ADDR_W  debug-unit word address.
REQ-011 o_wb_read_data  out  32  registered load result, extended per REQ-009.
REQ-012 o_wb_alu_result  out  32  registered copy of i_m_alu_result.
REQ-013 o_wb_rd  out  5  registered copy of i_m_rd.
REQ-014 o_wb_mem_to_reg, o_wb_reg_write  out  1 each  registered control bits.
REQ-015 o_wb_misaligned  out  1  registered flag: the access in WB was misaligned.
REQ-016 o_du_data  out  32  combinational word read at i_du_addr.

Function
REQ-017 The word index SHALL be i_m_alu_result[ADDR_W+1:2]; higher address bits are ignored, so addresses wrap modulo memory size.
REQ-018 Byte lanes SHALL be little-endian: addr[1:0]=0 maps to bits [7:0]; a halfword at addr[1]=0 maps to bits [15:0].
REQ-019 An access SHALL be misaligned when it is a halfword with addr[0]=1 or a word with addr[1:0]≠0; byte accesses are never misaligned.
REQ-020 A store SHALL write only the addressed lanes, on the rising edge where i_m_mem_write=1, i_halt=0 and the access is aligned.
REQ-021 A load SHALL read the memory combinationally and register the lane-selected, sign- or zero-extended value into o_wb_read_data on the next edge, giving 1-cycle latency.
REQ-022 o_wb_read_data SHALL be 0 when i_m_mem_read=0 or the access is misaligned.
REQ-023 A misaligned load or store SHALL set o_wb_misaligned=1 and force o_wb_reg_write=0 for that instruction; the memory is unchanged.
REQ-024 If both i_m_mem_read and i_m_mem_write are 1, the write SHALL occur and the read SHALL return the pre-write data.
REQ-025 A store followed by a load of the same word in the next cycle SHALL return the new data.
REQ-026 o_du_data SHALL return the pre-edge contents when the same word is being written in that cycle.
REQ-027 When i_halt=1, all o_wb_* outputs SHALL hold and no memory write SHALL occur; o_du_data SHALL remain live.

Reset
REQ-028 On i_reset=1, all o_wb_* outputs SHALL go to 0 immediately, independent of the clock.
REQ-029 Memory contents SHALL NOT be reset; they are retained through a reset asserted mid-operation.
REQ-030 A store presented in the same cycle that reset is asserted SHALL NOT write.

Structure
REQ-031 The bhw_type encodings SHALL reside in the shared package mips_pkg.
REQ-032 The lane-enable RAM SHALL be a sub-module named data_memory: one write port with 4 byte enables, one pipeline read port and one debug read port, both asynchronous.
REQ-033 Alignment checking, lane selection, extension and the M/WB output registers SHALL reside in mem_stage.

Verification
REQ-034 SW 0x8000_00F0 to addr 0x10, then LB addr 0x10 -> o_wb_read_data=0xFFFF_FFF0; LBU -> 0x0000_00F0.
REQ-035 SH 0x1234 to addr 0x22, then LW addr 0x20 -> upper 16 bits are 0x1234, lower 16 bits unchanged; LHU addr 0x22 -> 0x0000_1234.
REQ-036 LW addr 0x13 with reg_write=1 -> o_wb_misaligned=1, o_wb_reg_write=0, o_wb_read_data=0; SW addr 0x13 -> memory unchanged, checked via i_du_addr=4.
REQ-037 SW 0xA5A5_A5A5 to addr 0x40 with i_halt=1 -> o_du_data at addr 16 unchanged and o_wb_* held; repeat with i_halt=0 -> o_du_data=0xA5A5_A5A5 after the edge.
REQ-038 Write addr 0x0 = 0xDEAD_BEEF, pulse i_reset between clock edges -> o_wb_* = 0 immediately; o_du_data at addr 0 still reads 0xDEAD_BEEF.
